multi_debouncer: RTL and testbench

- Parametrised successor to the single-input debouncer.
- Debounces NUM_CH independent asynchronous inputs, typically buttons or switches on a board.
- Each channel has its own metastability synchroniser, its own stability counter, and a one-cycle rise/fall event pulse.
- Sits between board pins and the cell fabric; drives the global-channel ready flag once initialised.

---
 rtl/multi_debouncer.sv | 115 +++++++++++
 tb/tb_multi_debouncer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer: NUM_CH independent synchroniser + stability-counter debouncers
// with one-cycle rise/fall pulses and a global-channel ready flag.
//
// Ports:
//   gch_clk, gch_reset (async, active-high), gch_ready (high after first edge),
//   bouncing[NUM_CH] raw pins, steady[NUM_CH] debounced levels,
//   rise/fall[NUM_CH] one-cycle accept pulses.
//   With MULTI_DEBOUNCER_EVENT_LATCH_EN defined, adds evt_clr[NUM_CH],
//   evt_pend[NUM_CH] sticky event flags and irq (registered |evt_pend).
module multi_debouncer #(
  parameter int NUM_CH      = 4,
  parameter int TOT_CKS     = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] INIT_VAL = '0
) (
  input  logic              gch_clk,
  input  logic              gch_reset,
  output logic              gch_ready,
  input  logic [NUM_CH-1:0] bouncing,
  output logic [NUM_CH-1:0] steady,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
  ,
  input  logic [NUM_CH-1:0] evt_clr,
  output logic [NUM_CH-1:0] evt_pend,
  output logic              irq
`endif
);

  localparam int CW = $clog2(TOT_CKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TOT_CKS - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;
  logic [CW-1:0]     cnt    [NUM_CH];
  logic [CW-1:0]     cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] steady_d;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronisers reset to INIT_VAL so release never looks like an edge.
  always_ff @(posedge gch_clk or posedge gch_reset) begin
    if (gch_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= INIT_VAL;
    end else begin
      sync_q[0] <= bouncing;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    steady_d = steady;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt[i];
      if (gch_ready) begin
        if (s[i] != steady[i]) begin
          if (cnt[i] == LAST) begin
            steady_d[i] = s[i];
            cnt_d[i]    = '0;
            rise_d[i]   = s[i];
            fall_d[i]   = ~s[i];
          end else begin
            cnt_d[i] = cnt[i] + 1'b1;
          end
        end else begin
          // Any sample matching the current level restarts the count.
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge gch_clk or posedge gch_reset) begin
    if (gch_reset) begin
      gch_ready <= 1'b0;
      steady    <= INIT_VAL;
      rise      <= '0;
      fall      <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= '0;
    end else begin
      gch_ready <= 1'b1;
      steady    <= steady_d;
      rise      <= rise_d;
      fall      <= fall_d;
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= cnt_d[i];
    end
  end

`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
  logic [NUM_CH-1:0] pend_d;

  // Set is OR-ed after the clear so a new event beats a clear.
  assign pend_d = (evt_pend & ~evt_clr) | rise | fall;

  always_ff @(posedge gch_clk or posedge gch_reset) begin
    if (gch_reset) begin
      evt_pend <= '0;
      irq      <= 1'b0;
    end else begin
      evt_pend <= pend_d;
      irq      <= |pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Randomised + directed bench for multi_debouncer against a sample-window model.
// Model: pins delayed two edges, level accepted after four differing samples.
module tb_multi_debouncer;

  localparam logic [3:0] INIT = 4'b0100;

  logic       gch_clk;
  logic       gch_reset;
  logic       gch_ready;
  logic [3:0] bouncing;
  logic [3:0] steady;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] evt_clr;
`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
  logic [3:0] evt_pend;
  logic       irq;
`endif

  int nchk = 0;
  int nerr = 0;

  multi_debouncer #(
    .NUM_CH(4), .TOT_CKS(4), .SYNC_STAGES(2), .INIT_VAL(INIT)
  ) dut (
    .gch_clk(gch_clk),
    .gch_reset(gch_reset),
    .gch_ready(gch_ready),
    .bouncing(bouncing),
    .steady(steady),
    .rise(rise),
    .fall(fall)
`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
    ,
    .evt_clr(evt_clr),
    .evt_pend(evt_pend),
    .irq(irq)
`endif
  );

  initial gch_clk = 1'b0;
  always #5 gch_clk = ~gch_clk;

  // Reference model state
  logic [3:0]  m_pipe [2];
  logic [3:0]  m_steady;
  logic [3:0]  m_rise;
  logic [3:0]  m_fall;
  logic        m_ready;
  logic [15:0] m_hist [4];
  int          m_nh   [4];
  logic [3:0]  m_pend;
  logic        m_irq;

  task automatic model_reset();
    m_pipe[0] = INIT;
    m_pipe[1] = INIT;
    m_steady  = INIT;
    m_rise    = '0;
    m_fall    = '0;
    m_ready   = 1'b0;
    m_pend    = '0;
    m_irq     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '0;
      m_nh[i]   = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] b, input logic [3:0] c);
    logic [3:0] sv;
    m_pend = (m_pend & ~c) | m_rise | m_fall;
    m_irq  = |m_pend;
    sv = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = b;
    m_rise = '0;
    m_fall = '0;
    if (m_ready) begin
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][14:0], sv[i]};
        m_nh[i]++;
        if (m_nh[i] >= 4 &&
            m_hist[i][3:0] == (m_steady[i] ? 4'b0000 : 4'b1111)) begin
          m_steady[i] = ~m_steady[i];
          m_rise[i]   = m_steady[i];
          m_fall[i]   = ~m_steady[i];
          m_nh[i]     = 0;
        end
      end
    end
    m_ready = 1'b1;
  endtask

  function automatic logic [17:0] dut_vec();
    logic [17:0] v;
    v = {gch_ready, steady, rise, fall, 5'b0};
`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
    v[4:0] = {evt_pend, irq};
`endif
    return v;
  endfunction

  function automatic logic [17:0] model_vec();
    logic [17:0] v;
    v = {m_ready, m_steady, m_rise, m_fall, 5'b0};
`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
    v[4:0] = {m_pend, m_irq};
`endif
    return v;
  endfunction

  task automatic cyc(input logic [3:0] b, input logic [3:0] c);
    bouncing = b;
    evt_clr  = c;
    @(posedge gch_clk);
    model_edge(b, c);
    #1;
  endtask

  task automatic test_reset();
    gch_reset = 1'b1;
    bouncing  = INIT;
    evt_clr   = '0;
    model_reset();
    #1;
    nchk++;
    if ({gch_ready, steady, rise, fall} !== {1'b0, INIT, 8'h00}) begin
      nerr++;
      $display("FAIL reset_state got %b want %b",
               {gch_ready, steady, rise, fall}, {1'b0, INIT, 8'h00});
    end
    #1 gch_reset = 1'b0;
    cyc(INIT, 4'h0);
    nchk++;
    if (gch_ready !== 1'b1) begin
      nerr++;
      $display("FAIL ready_first_edge got %b want 1", gch_ready);
    end
    for (int k = 0; k < 3; k++) cyc(4'b0101, 4'h0);
    #2 gch_reset = 1'b1;
    bouncing = INIT;
    model_reset();
    #1;
    nchk++;
    if ({gch_ready, steady, rise, fall} !== {1'b0, INIT, 8'h00}) begin
      nerr++;
      $display("FAIL reset_midcount got %b want %b",
               {gch_ready, steady, rise, fall}, {1'b0, INIT, 8'h00});
    end
    #2 gch_reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(INIT, 4'h0);
      nchk++;
      if (dut_vec() !== model_vec() || (rise | fall) !== 4'h0) begin
        nerr++;
        $display("FAIL reset_after k=%0d got %h want %h",
                 k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_rise();
    int first = 0;
    int nrise = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc(4'b0101, 4'h0);
      nchk++;
      if (dut_vec() !== model_vec()) begin
        nerr++;
        $display("FAIL rise_cyc k=%0d got %h want %h",
                 k, dut_vec(), model_vec());
      end
      if (rise[0]) nrise++;
      if (steady[0] && first == 0) first = k;
    end
    nchk++;
    if (first != 6) begin
      nerr++;
      $display("FAIL rise_latency got %0d want 6", first);
    end
    nchk++;
    if (nrise != 1 || steady !== 4'b0101) begin
      nerr++;
      $display("FAIL rise_single got %0d/%b want 1/0101", nrise, steady);
    end
  endtask

  task automatic test_glitch();
    logic [27:0] pat;
    int nr = 0;
    int nf = 0;
    pat = 28'b0000000000_1111_000001110111;
    for (int k = 0; k < 28; k++) begin
      cyc({2'b01, pat[k], 1'b1}, 4'h0);
      nchk++;
      if (dut_vec() !== model_vec()) begin
        nerr++;
        $display("FAIL glitch_cyc k=%0d got %h want %h",
                 k, dut_vec(), model_vec());
      end
      if (rise[1]) nr++;
      if (fall[1]) nf++;
      if (k == 13) begin
        nchk++;
        if (nr != 0 || steady[1] !== 1'b0) begin
          nerr++;
          $display("FAIL glitch_reject got %0d/%b want 0/0", nr, steady[1]);
        end
      end
    end
    nchk++;
    if (nr != 1 || nf != 1) begin
      nerr++;
      $display("FAIL glitch_accept got %0d/%0d want 1/1", nr, nf);
    end
  endtask

  task automatic test_simultaneous();
    int k3 = 0;
    int k2 = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(k <= 8 ? 4'b0100 : 4'b1000, 4'h0);
      nchk++;
      if (dut_vec() !== model_vec()) begin
        nerr++;
        $display("FAIL simul_cyc k=%0d got %h want %h",
                 k, dut_vec(), model_vec());
      end
      if (rise[3]) k3 = k;
      if (fall[2]) k2 = k;
    end
    nchk++;
    if (k3 != 14 || k2 != 14) begin
      nerr++;
      $display("FAIL simul_same_cycle got %0d/%0d want 14/14", k3, k2);
    end
    nchk++;
    if (steady !== 4'b1000) begin
      nerr++;
      $display("FAIL simul_steady got %b want 1000", steady);
    end
  endtask

  task automatic test_reset_init();
    int first = 0;
    #2 gch_reset = 1'b1;
    bouncing = 4'b0101;
    model_reset();
    #1 bouncing = 4'b0100;
    nchk++;
    if ({gch_ready, steady, rise, fall} !== {1'b0, INIT, 8'h00}) begin
      nerr++;
      $display("FAIL init_reset got %b want %b",
               {gch_ready, steady, rise, fall}, {1'b0, INIT, 8'h00});
    end
    #1 bouncing = 4'b0101;
    #1 gch_reset = 1'b0;
    cyc(4'b0100, 4'h0);
    nchk++;
    if (dut_vec() !== model_vec() || (rise | fall) !== 4'h0) begin
      nerr++;
      $display("FAIL init_edge got %h want %h", dut_vec(), model_vec());
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(4'b0101, 4'h0);
      nchk++;
      if (dut_vec() !== model_vec()) begin
        nerr++;
        $display("FAIL init_cyc k=%0d got %h want %h",
                 k, dut_vec(), model_vec());
      end
      if (steady[0] && first == 0) first = k;
    end
    nchk++;
    if (first != 6) begin
      nerr++;
      $display("FAIL init_full_count got %0d want 6", first);
    end
  endtask

`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
  task automatic test_event_latch();
    int n;
    for (int k = 0; k < 8; k++) cyc(4'b0100, 4'h0);
    cyc(4'b0100, 4'hf);
    cyc(4'b0100, 4'hf);
    n = 0;
    while (!rise[0] && n < 12) begin
      cyc(4'b0101, 4'h0);
      n++;
    end
    cyc(4'b0101, 4'h0);
    nchk++;
    if (n >= 12 || evt_pend !== 4'b0001 || irq !== 1'b1) begin
      nerr++;
      $display("FAIL evt_set got %b/%b want 0001/1", evt_pend, irq);
    end
    n = 0;
    while (!fall[0] && n < 12) begin
      cyc(4'b0100, 4'h0);
      n++;
    end
    cyc(4'b0100, 4'b0001);
    nchk++;
    if (n >= 12 || evt_pend[0] !== 1'b1 || dut_vec() !== model_vec()) begin
      nerr++;
      $display("FAIL evt_set_wins got %b want 1", evt_pend[0]);
    end
    cyc(4'b0100, 4'b0001);
    nchk++;
    if (evt_pend !== 4'b0000 || irq !== 1'b0) begin
      nerr++;
      $display("FAIL evt_clear got %b/%b want 0000/0", evt_pend, irq);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] b;
    logic [3:0] c;
    b = bouncing;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(4) == 0) b[i] = ~b[i];
      c = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(149) == 0) begin
        #2 gch_reset = 1'b1;
        model_reset();
        #1;
        nchk++;
        if (dut_vec() !== model_vec()) begin
          nerr++;
          $display("FAIL rand_reset k=%0d got %h want %h",
                   k, dut_vec(), model_vec());
        end
        #2 gch_reset = 1'b0;
      end
      cyc(b, c);
      nchk++;
      if (dut_vec() !== model_vec() || (rise & fall) !== 4'h0) begin
        nerr++;
        $display("FAIL rand_cyc k=%0d got %h want %h",
                 k, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_simultaneous();
    test_reset_init();
`ifdef MULTI_DEBOUNCER_EVENT_LATCH_EN
    test_event_latch();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
